// File: rtl/osc_state_bank_pkg.sv
// Shared constants and state type for the oscillator state bank.
// OSC_IDLE is the slot number osc_num parks on between sweeps.
package osc_pkg;

    localparam int OSC_N  = 24;
    localparam int OSC_CW = 20;
    localparam int OSC_VW = 7;
    localparam logic [6:0] OSC_IDLE = 7'(OSC_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } osc_state_e;

endpackage

// File: rtl/osc_state_bank_slot_seq.sv
// Sweep sequencer: steps osc_num through slots 0..N-1 once per accepted
// sample_tick, then parks on N. The FSM state is exported on state_o.
module osc_slot_seq
    import osc_pkg::*;
#(
    parameter int N = OSC_N
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sample_tick,
    output logic [6:0] osc_num,
    output logic       sweep_busy,
    output logic       sweep_done,
    output osc_state_e state_o
);

    osc_state_e state_q;
    logic [6:0] osc_num_q;
    logic       busy_q;
    logic       done_q;

    // sample_tick during SCAN is deliberately not looked at here: the sweep
    // in progress always runs to completion.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            osc_num_q <= 7'(N);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sample_tick) begin
                        state_q   <= SCAN;
                        osc_num_q <= 7'd0;
                        busy_q    <= 1'b1;
                    end
                end
                SCAN: begin
                    if (osc_num_q == 7'(N - 1)) begin
                        state_q   <= DONE;
                        osc_num_q <= 7'(N);
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        osc_num_q <= osc_num_q + 7'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (sample_tick) begin
                        state_q   <= SCAN;
                        osc_num_q <= 7'd0;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    osc_num_q <= 7'(N);
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign osc_num    = osc_num_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign state_o    = state_q;

endmodule

// File: rtl/osc_state_bank.sv
// Per-oscillator count / velocity / ended-note arrays written back during a sweep.
// Define OSC_BANK_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is 0.
module osc_state_bank
    import osc_pkg::*;
#(
    parameter int N  = OSC_N,
    parameter int CW = OSC_CW,
    parameter int VW = OSC_VW
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            sample_tick,
    output logic [6:0]      osc_num,
    output logic            sweep_busy,
    output logic            sweep_done,
    input  logic            wr_en,
    input  logic [CW-1:0]   count_next,
    input  logic            new_note,
    input  logic [VW-1:0]   new_note_velocity,
    input  logic            ended_set,
    output logic [N*CW-1:0] count,
    output logic [N*VW-1:0] current_velocity,
    output logic [N-1:0]    ended_note,
    output logic            overrun
);

    osc_state_e state;

    logic [CW-1:0] count_q [N];
    logic [CW-1:0] count_d [N];
    logic [VW-1:0] vel_q   [N];
    logic [VW-1:0] vel_d   [N];
    logic [N-1:0]  ended_q;
    logic [N-1:0]  ended_d;
    logic          wr_ok;

    osc_slot_seq #(.N(N)) u_seq (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_tick (sample_tick),
        .osc_num     (osc_num),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .state_o     (state)
    );

    assign wr_ok = (state == SCAN) && (osc_num < 7'(N));

    // One strobe wins per slot and cycle: new_note, then ended_set, then wr_en.
    always_comb begin
        count_d = count_q;
        vel_d   = vel_q;
        ended_d = ended_q;
        for (int i = 0; i < N; i++) begin
            if (wr_ok && (osc_num == 7'(i))) begin
                if (new_note) begin
                    count_d[i] = '0;
                    vel_d[i]   = new_note_velocity;
                    ended_d[i] = 1'b0;
                end else if (ended_set) begin
                    ended_d[i] = 1'b1;
                end else if (wr_en) begin
                    count_d[i] = count_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= '0;
                vel_q[i]   <= '0;
            end
            ended_q <= '0;
        end else begin
            count_q <= count_d;
            vel_q   <= vel_d;
            ended_q <= ended_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign count[g*CW +: CW]            = count_q[g];
        assign current_velocity[g*VW +: VW] = vel_q[g];
    end
    assign ended_note = ended_q;

`ifdef OSC_BANK_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_q <= 1'b0;
        end else if (sample_tick && (state == SCAN)) begin
            overrun_q <= 1'b1;
        end else if (sample_tick && (state == IDLE)) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
